// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared constants and the next-PC select encoding for pc_unit.
// Contents : PC_INIT_DEF, EXC_VEC_DEF, PC_INC_DEF, npc_sel_e
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

  localparam logic [31:0] PC_INIT_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF = 32'h0000_4180;
  localparam int          PC_INC_DEF  = 4;

  // Source of the next PC value, listed loosely from lowest to highest
  // priority; the actual priority is resolved in pc_unit.
  typedef enum logic [2:0] {
    NPC_SEQ   = 3'd0,
    NPC_HOLD  = 3'd1,
    NPC_REDIR = 3'd2,
    NPC_PEND  = 3'd3,
    NPC_EXC   = 3'd4,
    NPC_ERET  = 3'd5
  } npc_sel_e;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_redirect_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_buf
// Purpose  : One-entry buffer holding a branch/jump redirect that arrived
//            while the fetch stage was stalled.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            capture         - load capture_tgt and mark the entry valid
//            clear           - drop the entry (wins over capture)
//            capture_tgt     - target to store
//            valid           - an entry is held
//            pend_tgt        - stored target
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] capture_tgt,
  output logic             valid,
  output logic [WIDTH-1:0] pend_tgt
);

  logic             pend_q;
  logic [WIDTH-1:0] pend_tgt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else if (clear) begin
      pend_q     <= 1'b0;
    end else if (capture) begin
      // A newer redirect during the same stall simply overwrites the older one.
      pend_q     <= 1'b1;
      pend_tgt_q <= capture_tgt;
    end
  end

  assign valid    = pend_q;
  assign pend_tgt = pend_tgt_q;

endmodule : pc_redirect_buf
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Program counter for the single-issue MIPS front end. Handles
//            stall, branch/jump redirect (buffered while stalled), exception
//            entry and eret return. Optional macro PC_ALIGN_CHECK_EN adds
//            the misalign_o fetch-address flag.
// Ports    : clk, reset       - clock, synchronous active-high reset
//            stall_i          - hold PC
//            redir_valid_i    - redirect request, redir_target_i target
//            exc_i            - jump to EXC_VEC
//            eret_i           - jump to epc_i
//            pc_o, pc_plus_o  - current PC and PC + INC
//            pend_o           - buffered redirect pending
//            misalign_o       - pc_o[1:0] != 0 (PC_ALIGN_CHECK_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit
  import pc_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] PC_INIT = PC_INIT_DEF,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF,
  parameter int          INC     = PC_INC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redir_valid_i,
  input  logic [WIDTH-1:0] redir_target_i,
  input  logic             exc_i,
  input  logic             eret_i,
  input  logic [WIDTH-1:0] epc_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
`ifdef PC_ALIGN_CHECK_EN
  output logic             misalign_o,
`endif
  output logic             pend_o
);

  // Wide constants are truncated to the PC width; arithmetic wraps.
  localparam logic [WIDTH-1:0] PC_INIT_W = PC_INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] EXC_VEC_W = EXC_VEC[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INC_W     = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] pc_plus;
  npc_sel_e         npc_sel;
  logic             buf_capture;
  logic             buf_clear;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_tgt;

  pc_redirect_buf #(
    .WIDTH (WIDTH)
  ) u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .capture     (buf_capture),
    .clear       (buf_clear),
    .capture_tgt (redir_target_i),
    .valid       (buf_valid),
    .pend_tgt    (buf_tgt)
  );

  assign pc_plus = pc_q + INC_W;

  // Priority select. Exception and eret ignore the stall; a live redirect
  // supersedes anything already buffered.
  always_comb begin
    npc_sel     = NPC_SEQ;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    if (exc_i) begin
      npc_sel   = NPC_EXC;
      buf_clear = 1'b1;
    end else if (eret_i) begin
      npc_sel   = NPC_ERET;
      buf_clear = 1'b1;
    end else if (redir_valid_i && !stall_i) begin
      npc_sel   = NPC_REDIR;
      buf_clear = 1'b1;
    end else if (redir_valid_i) begin
      npc_sel     = NPC_HOLD;
      buf_capture = 1'b1;
    end else if (buf_valid && !stall_i) begin
      npc_sel   = NPC_PEND;
      buf_clear = 1'b1;
    end else if (stall_i) begin
      npc_sel = NPC_HOLD;
    end
  end

  always_comb begin
    pc_next = pc_plus;
    case (npc_sel)
      NPC_SEQ:   pc_next = pc_plus;
      NPC_HOLD:  pc_next = pc_q;
      NPC_REDIR: pc_next = redir_target_i;
      NPC_PEND:  pc_next = buf_tgt;
      NPC_EXC:   pc_next = EXC_VEC_W;
      NPC_ERET:  pc_next = epc_i;
      default:   pc_next = pc_plus;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_INIT_W;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc_o      = pc_q;
  assign pc_plus_o = pc_plus;
  assign pend_o    = buf_valid;

`ifdef PC_ALIGN_CHECK_EN
  // Informational only; sequencing is unaffected and the exception unit
  // reacts through exc_i.
  assign misalign_o = (pc_q[1:0] != 2'b00);
`endif

endmodule : pc_unit
`default_nettype wire
